// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined Hack-style ALU with valid/ready handshake
// and status flags.
//
// Stage 1 registers the operands and control on accept. Stage 2 evaluates
// the ALU from the stage-1 contents and registers the result and flags. It
// also serves as the output register.
//
// Parameters:
//   WIDTH      operand/result width in bits (>= 2)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operation presented on in_*
//   in_ready   block accepts the operation this cycle
//   in_x/in_y  operands
//   in_ctl     {zx,nx,zy,ny,f,no}
//   in_acc     use accumulator in place of in_y (only with ALU_ACC_EN)
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   out_data   result (0 while out_valid=0)
//   out_zr     result == 0
//   out_ng     result MSB
//   out_cout   adder carry-out (before the no inversion)
//   out_ovf    signed overflow of the add (before the no inversion)
//
// Optional feature macro: ALU_ACC_EN
//   When defined, an accumulator holds the result of the previous operation.
//   An operation with in_acc=1 uses that accumulator in place of in_y.
module alu_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [5:0]       in_ctl,
  input  logic             in_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zr,
  output logic             out_ng,
  output logic             out_cout,
  output logic             out_ovf
);

  // Returns {cout, ovf, R}. cout and ovf are captured before the no inversion.
  function automatic logic [WIDTH+1:0] alu_eval(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic [5:0]       ctl);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] r;
    logic [WIDTH:0]   sum;
    logic             c;
    logic             v;
    a   = ctl[5] ? '0 : x;
    a   = ctl[4] ? ~a : a;
    b   = ctl[3] ? '0 : y;
    b   = ctl[2] ? ~b : b;
    sum = {1'b0, a} + {1'b0, b};
    if (ctl[1]) begin
      r = sum[WIDTH-1:0];
      c = sum[WIDTH];
      v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    end else begin
      r = a & b;
      c = 1'b0;
      v = 1'b0;
    end
    if (ctl[0]) r = ~r;
    return {c, v, r};
  endfunction

  logic             r_vld_p1;
  logic [WIDTH-1:0] r_x_p1;
  logic [WIDTH-1:0] r_y_p1;
  logic [5:0]       r_ctl_p1;

  logic             r_vld_p2;
  logic [WIDTH-1:0] r_data_p2;
  logic             r_zr_p2;
  logic             r_ng_p2;
  logic             r_cout_p2;
  logic             r_ovf_p2;

  logic             w_s2_load;
  logic             w_accept;
  logic             w_xfer;
  logic [WIDTH-1:0] w_y_src;
  logic [WIDTH+1:0] w_res;

  // Ready propagates combinationally back from the consumer, so a full
  // pipeline still accepts one op per cycle while the output drains.
  assign w_s2_load = !r_vld_p2 || out_ready;
  assign in_ready  = !r_vld_p1 || w_s2_load;
  assign w_accept  = in_valid && in_ready;
  assign w_xfer    = r_vld_p1 && w_s2_load;

  // ---- Stage 1: operand capture ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
      r_x_p1   <= '0;
      r_y_p1   <= '0;
      r_ctl_p1 <= '0;
    end else begin
      if (w_accept)    r_vld_p1 <= 1'b1;
      else if (w_xfer) r_vld_p1 <= 1'b0;
      if (w_accept) begin
        r_x_p1   <= in_x;
        r_y_p1   <= in_y;
        r_ctl_p1 <= in_ctl;
      end
    end
  end

`ifdef ALU_ACC_EN
  logic             r_acc_sel_p1;
  logic [WIDTH-1:0] r_acc;

  // The accumulator updates on the same edge as stage 2. The op now in
  // stage 1 therefore always sees the result of its immediate predecessor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_sel_p1 <= 1'b0;
      r_acc        <= '0;
    end else begin
      if (w_accept) r_acc_sel_p1 <= in_acc;
      if (w_xfer)   r_acc        <= w_res[WIDTH-1:0];
    end
  end

  assign w_y_src = r_acc_sel_p1 ? r_acc : r_y_p1;
`else
  logic w_unused_acc;
  assign w_unused_acc = in_acc;
  assign w_y_src      = r_y_p1;
`endif

  assign w_res = alu_eval(r_x_p1, w_y_src, r_ctl_p1);

  // ---- Stage 2: result and flags (output register) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p2  <= 1'b0;
      r_data_p2 <= '0;
      r_zr_p2   <= 1'b0;
      r_ng_p2   <= 1'b0;
      r_cout_p2 <= 1'b0;
      r_ovf_p2  <= 1'b0;
    end else begin
      if (w_s2_load) r_vld_p2 <= r_vld_p1;
      if (w_xfer) begin
        r_data_p2 <= w_res[WIDTH-1:0];
        r_zr_p2   <= ~|w_res[WIDTH-1:0];
        r_ng_p2   <= w_res[WIDTH-1];
        r_cout_p2 <= w_res[WIDTH+1];
        r_ovf_p2  <= w_res[WIDTH];
      end
    end
  end

  // Outputs are gated so that stale stage-2 contents never leak out.
  assign out_valid = r_vld_p2;
  assign out_data  = r_vld_p2 ? r_data_p2 : '0;
  assign out_zr    = r_vld_p2 && r_zr_p2;
  assign out_ng    = r_vld_p2 && r_ng_p2;
  assign out_cout  = r_vld_p2 && r_cout_p2;
  assign out_ovf   = r_vld_p2 && r_ovf_p2;

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

  typedef struct {
    logic [63:0] d;
    logic [3:0]  fl;   // {zr, ng, cout, ovf}
    int          cyc;
    bit          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;
  int n_out = 0;

  // WIDTH=16 instance
  logic        in_valid = 1'b0, in_ready, in_acc = 1'b0;
  logic [15:0] in_x = '0, in_y = '0;
  logic [5:0]  in_ctl = '0;
  logic        out_valid, out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_zr, out_ng, out_cout, out_ovf;

  // WIDTH=8 instance
  logic        in_valid_8 = 1'b0, in_ready_8;
  logic [7:0]  in_x_8 = '0, in_y_8 = '0;
  logic [5:0]  in_ctl_8 = '0;
  logic        out_valid_8;
  logic [7:0]  out_data_8;
  logic        out_zr_8, out_ng_8, out_cout_8, out_ovf_8;

  // WIDTH=32 instance
  logic        in_valid_32 = 1'b0, in_ready_32;
  logic [31:0] in_x_32 = '0, in_y_32 = '0;
  logic [5:0]  in_ctl_32 = '0;
  logic        out_valid_32;
  logic [31:0] out_data_32;
  logic        out_zr_32, out_ng_32, out_cout_32, out_ovf_32;

  alu_pipe #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_ctl(in_ctl), .in_acc(in_acc),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_zr(out_zr), .out_ng(out_ng), .out_cout(out_cout), .out_ovf(out_ovf));

  alu_pipe #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_8), .in_ready(in_ready_8),
    .in_x(in_x_8), .in_y(in_y_8), .in_ctl(in_ctl_8), .in_acc(1'b0),
    .out_valid(out_valid_8), .out_ready(1'b1), .out_data(out_data_8),
    .out_zr(out_zr_8), .out_ng(out_ng_8), .out_cout(out_cout_8), .out_ovf(out_ovf_8));

  alu_pipe #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_32), .in_ready(in_ready_32),
    .in_x(in_x_32), .in_y(in_y_32), .in_ctl(in_ctl_32), .in_acc(1'b0),
    .out_valid(out_valid_32), .out_ready(1'b1), .out_data(out_data_32),
    .out_zr(out_zr_32), .out_ng(out_ng_32), .out_cout(out_cout_32), .out_ovf(out_ovf_32));

  exp_t q16[$];
  exp_t q8[$];
  exp_t q32[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic bad(input string nm, input logic [63:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got 0x%0h, expected none (t=%0t)", nm, act, $time);
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send16(input logic [15:0] x, input logic [15:0] y,
                        input logic [5:0] ctl, input logic acc,
                        input logic [15:0] d, input logic [3:0] fl, input bit lat);
    exp_t e;
    int   n;
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    in_ctl   = ctl;
    in_acc   = acc;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      bad("accept_timeout", {48'h0, d});
    end else begin
      e.d = {48'h0, d}; e.fl = fl; e.cyc = cyc; e.lat = lat;
      q16.push_back(e);
      n_acc++;
    end
    @(negedge clk);
  endtask

  // Monitor for the 16-bit instance
  exp_t m16;
  always @(negedge clk) begin
    #2;
    if (out_valid && out_ready) begin
      if (q16.size() == 0) bad("unexpected_out16", {48'h0, out_data});
      else begin
        m16 = q16.pop_front();
        chk("data16", {48'h0, out_data}, m16.d);
        chk("flags16", {60'h0, out_zr, out_ng, out_cout, out_ovf}, {60'h0, m16.fl});
        if (m16.lat) chk("latency16", 64'(cyc - m16.cyc), 64'd2);
        n_out++;
      end
    end else if (out_valid) begin
      if (q16.size() == 0) bad("unexpected_hold16", {48'h0, out_data});
      else chk("hold16", {48'h0, out_data}, q16[0].d);
    end else begin
      chk("masked16", {44'h0, out_data, out_zr, out_ng, out_cout, out_ovf}, 64'h0);
    end
  end

  exp_t m8;
  always @(negedge clk) begin
    #2;
    if (out_valid_8) begin
      if (q8.size() == 0) bad("unexpected_out8", {56'h0, out_data_8});
      else begin
        m8 = q8.pop_front();
        chk("data8", {56'h0, out_data_8}, m8.d);
        chk("flags8", {60'h0, out_zr_8, out_ng_8, out_cout_8, out_ovf_8}, {60'h0, m8.fl});
        chk("latency8", 64'(cyc - m8.cyc), 64'd2);
      end
    end
  end

  exp_t m32;
  always @(negedge clk) begin
    #2;
    if (out_valid_32) begin
      if (q32.size() == 0) bad("unexpected_out32", {32'h0, out_data_32});
      else begin
        m32 = q32.pop_front();
        chk("data32", {32'h0, out_data_32}, m32.d);
        chk("flags32", {60'h0, out_zr_32, out_ng_32, out_cout_32, out_ovf_32}, {60'h0, m32.fl});
        chk("latency32", 64'(cyc - m32.cyc), 64'd2);
      end
    end
  end

  initial begin
    exp_t e;
    int   a0, o0, n;

    // Reset state
    #1;
    chk("rst_in_ready", {63'h0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'h0, out_valid}, 64'd0);
    chk("rst_out_data", {48'h0, out_data}, 64'd0);
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);

    // Hack truth table and flags, back to back with unstalled output
    send16(16'h0005, 16'h0003, 6'b000010, 1'b0, 16'h0008, 4'b0000, 1'b1);
    send16(16'h0005, 16'h0003, 6'b010011, 1'b0, 16'h0002, 4'b0000, 1'b1);
    send16(16'h0005, 16'h0003, 6'b000111, 1'b0, 16'hFFFE, 4'b0110, 1'b1);
    send16(16'h0005, 16'h0003, 6'b101010, 1'b0, 16'h0000, 4'b1000, 1'b1);
    send16(16'h0005, 16'h0003, 6'b000000, 1'b0, 16'h0001, 4'b0000, 1'b1);
    send16(16'h0005, 16'h0003, 6'b001100, 1'b0, 16'h0005, 4'b0000, 1'b1);
    send16(16'h7FFF, 16'h0001, 6'b000010, 1'b0, 16'h8000, 4'b0101, 1'b1);
    send16(16'hFFFF, 16'h0001, 6'b000010, 1'b0, 16'h0000, 4'b1010, 1'b1);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);

    // Other widths
    in_valid_8 = 1'b1; in_x_8 = 8'h80; in_y_8 = 8'h80; in_ctl_8 = 6'b000010;
    e.d = 64'h0; e.fl = 4'b1011; e.cyc = cyc; e.lat = 1'b1; q8.push_back(e);
    in_valid_32 = 1'b1; in_x_32 = 32'hFFFFFFFF; in_y_32 = 32'h12345678; in_ctl_32 = 6'b001100;
    e.d = 64'hFFFFFFFF; e.fl = 4'b0100; e.cyc = cyc; e.lat = 1'b1; q32.push_back(e);
    @(negedge clk);
    in_valid_8 = 1'b0; in_valid_32 = 1'b0;
    repeat (4) @(negedge clk);

    // Backpressure: 4 ops with the consumer stalled
    out_ready = 1'b0;
    a0 = n_acc;
    fork
      begin
        send16(16'h0001, 16'h0010, 6'b000010, 1'b0, 16'h0011, 4'b0000, 1'b0);
        send16(16'h0002, 16'h0010, 6'b000010, 1'b0, 16'h0012, 4'b0000, 1'b0);
        send16(16'h0003, 16'h0010, 6'b000010, 1'b0, 16'h0013, 4'b0000, 1'b0);
        send16(16'h0004, 16'h0010, 6'b000010, 1'b0, 16'h0014, 4'b0000, 1'b0);
        in_valid = 1'b0;
      end
    join_none
    repeat (5) @(negedge clk);
    #3;
    chk("bp_accepts", 64'(n_acc - a0), 64'd2);
    chk("bp_in_ready", {63'h0, in_ready}, 64'd0);
    @(negedge clk);
    o0 = n_out;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    #3;
    chk("bp_drain_count", 64'(n_out - o0), 64'd4);
    wait fork;
    repeat (3) @(negedge clk);

    // Accumulator chain
    send16(16'h0001, 16'h0001, 6'b000010, 1'b0, 16'h0002, 4'b0000, 1'b1);
`ifdef ALU_ACC_EN
    send16(16'h0001, 16'h0010, 6'b000010, 1'b1, 16'h0003, 4'b0000, 1'b1);
    send16(16'h0001, 16'h0010, 6'b000010, 1'b1, 16'h0004, 4'b0000, 1'b1);
    send16(16'h0001, 16'h0010, 6'b000010, 1'b1, 16'h0005, 4'b0000, 1'b1);
`else
    send16(16'h0001, 16'h0010, 6'b000010, 1'b1, 16'h0011, 4'b0000, 1'b1);
    send16(16'h0001, 16'h0010, 6'b000010, 1'b1, 16'h0011, 4'b0000, 1'b1);
    send16(16'h0001, 16'h0010, 6'b000010, 1'b1, 16'h0011, 4'b0000, 1'b1);
`endif
    in_valid = 1'b0;
    repeat (4) @(negedge clk);

    // Reset with both stages full
    out_ready = 1'b0;
    send16(16'h0005, 16'h0003, 6'b000010, 1'b0, 16'h0008, 4'b0000, 1'b0);
    send16(16'h0006, 16'h0003, 6'b000010, 1'b0, 16'h0009, 4'b0000, 1'b0);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    q16.delete();
    #1;
    chk("midrst_out_valid", {63'h0, out_valid}, 64'd0);
    chk("midrst_out_data", {48'h0, out_data}, 64'd0);
    chk("midrst_in_ready", {63'h0, in_ready}, 64'd1);
    repeat (2) @(negedge clk);
    #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);

    // Drain check
    n = 0;
    while ((q16.size() != 0 || q8.size() != 0 || q32.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("queues_empty", 64'(q16.size() + q8.size() + q32.size()), 64'd0);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
